prbs_burst_ctrl: RTL and testbench

Sequencer for the QPSK transmitter's two PRBS9 generators (I and Q branches). Reloads both generators with their seeds on command, then issues one advance strobe per symbol at a rate of one symbol per OS clocks, for a programmed burst length or continuously. Sits between the control/register interface and the PRBS generators. Its symbol strobe also feeds the downstream mapper/upsampler.

---
 rtl/prbs_burst_ctrl_pkg.sv | 16 +
 rtl/prbs_burst_ctrl_os_phase_counter.sv | 26 ++
 rtl/prbs_burst_ctrl.sv | 98 +++++++++
 tb/tb_prbs_burst_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/prbs_burst_ctrl_pkg.sv
// Shared types and constants for the PRBS burst sequencer.
package prbs_burst_ctrl_pkg;

  localparam int unsigned NB_SEED = 9;

  localparam logic [NB_SEED-1:0] SEED_I_DEF = 9'h1AA;
  localparam logic [NB_SEED-1:0] SEED_Q_DEF = 9'h1FE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/prbs_burst_ctrl_os_phase_counter.sv
// Modulo-OS symbol phase counter with synchronous clear and enable.
module os_phase_counter #(
  parameter int unsigned OS = 4,
  localparam int unsigned PW = (OS > 1) ? $clog2(OS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [PW-1:0] phase,
  output logic          tc_c
);

  assign tc_c = (phase == PW'(OS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= tc_c ? '0 : PW'(phase + 1'b1);
    end
  end

endmodule

// File: rtl/prbs_burst_ctrl.sv
// Burst sequencer: seed reload, then one advance strobe every OS clocks.
module prbs_burst_ctrl
  import prbs_burst_ctrl_pkg::*;
#(
  parameter int unsigned         OS      = 4,
  parameter int unsigned         NB_LEN  = 16,
  parameter int unsigned         NB_SEED = prbs_burst_ctrl_pkg::NB_SEED,
  parameter logic [NB_SEED-1:0]  SEED_I  = prbs_burst_ctrl_pkg::SEED_I_DEF,
  parameter logic [NB_SEED-1:0]  SEED_Q  = prbs_burst_ctrl_pkg::SEED_Q_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic [NB_LEN-1:0] burst_len,
  output logic              prbs_load,
  output logic              prbs_en,
  output logic [NB_SEED-1:0] seed_i,
  output logic [NB_SEED-1:0] seed_q,
  output logic              sym_strobe,
  output logic              busy,
  output logic              done,
  output logic [NB_LEN-1:0] sym_cnt
);

  localparam int unsigned PW = (OS > 1) ? $clog2(OS) : 1;

  state_t            state;
  logic [NB_LEN-1:0] len_q;
  logic              cont_q;
  logic [NB_LEN-1:0] sym_cnt_nxt;
  logic              strobe;
  logic              tc;
  logic [PW-1:0]     unused_phase;

  // Phase only advances in RUN; every other state holds it at zero.
  os_phase_counter #(.OS(OS)) u_phase (
    .clk   (clk),
    .rst   (rst),
    .clr   (state != ST_RUN),
    .en    (state == ST_RUN),
    .phase (unused_phase),
    .tc_c  (tc)
  );

  assign strobe      = (state == ST_RUN) && tc;
  assign sym_cnt_nxt = sym_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      len_q   <= '0;
      cont_q  <= 1'b0;
      sym_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            state   <= ST_LOAD;
            len_q   <= burst_len;
            cont_q  <= continuous;
            sym_cnt <= '0;
          end
        end
        ST_LOAD: begin
          state <= ((len_q == '0) && !cont_q) ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          // A strobe decoded in the stop cycle is still counted.
          if (strobe) begin
            sym_cnt <= sym_cnt_nxt;
          end
          if (stop) begin
            state <= ST_IDLE;
          end else if (strobe && !cont_q && (sym_cnt_nxt == len_q)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign prbs_load  = (state == ST_LOAD);
  assign prbs_en    = strobe;
  assign sym_strobe = strobe;
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign seed_i     = SEED_I;
  assign seed_q     = SEED_Q;

endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// Directed bench for prbs_burst_ctrl: vector table of bursts plus hand-written corner sequences.
module tb_prbs_burst_ctrl;

  localparam int unsigned OS     = 4;
  localparam int unsigned NB_LEN = 16;
  localparam int unsigned NB_L4  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              start, stop, continuous;
  logic [NB_LEN-1:0] burst_len;
  logic              prbs_load, prbs_en, sym_strobe, busy, done;
  logic [8:0]        seed_i, seed_q;
  logic [NB_LEN-1:0] sym_cnt;

  logic              start4, stop4, cont4;
  logic [NB_L4-1:0]  burst_len4;
  logic              prbs_load4, prbs_en4, sym_strobe4, busy4, done4;
  logic [8:0]        seed_i4, seed_q4;
  logic [NB_L4-1:0]  sym_cnt4;

  prbs_burst_ctrl #(.OS(OS), .NB_LEN(NB_LEN)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
    .burst_len(burst_len), .prbs_load(prbs_load), .prbs_en(prbs_en),
    .seed_i(seed_i), .seed_q(seed_q), .sym_strobe(sym_strobe), .busy(busy),
    .done(done), .sym_cnt(sym_cnt)
  );

  prbs_burst_ctrl #(.OS(OS), .NB_LEN(NB_L4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .stop(stop4), .continuous(cont4),
    .burst_len(burst_len4), .prbs_load(prbs_load4), .prbs_en(prbs_en4),
    .seed_i(seed_i4), .seed_q(seed_q4), .sym_strobe(sym_strobe4), .busy(busy4),
    .done(done4), .sym_cnt(sym_cnt4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Cycle 0 is the cycle start is driven high; -1 means "never".
  typedef struct {
    string name;
    int    len;
    int    stop_cyc;
    int    start2_cyc;
    int    lchg_cyc;
    int    new_len;
    int    exp_strobes;
    int    exp_done;
    int    exp_busy_last;
    int    exp_cnt;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  task automatic run_vec(input vec_t v);
    int load_cyc = -1, strobes = 0, last_strobe = -1, spacing_err = 0;
    int done_cyc = -1, busy_first = -1, busy_last = -1, busy_n = 0, eq_err = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (prbs_load && load_cyc < 0) load_cyc = c;
      if (prbs_en) begin
        if ((last_strobe < 0) ? (c != 1 + OS) : (c - last_strobe != OS)) spacing_err++;
        strobes++;
        last_strobe = c;
      end
      if (sym_strobe !== prbs_en) eq_err++;
      if (done) done_cyc = (done_cyc < 0) ? c : 999;
      if (busy) begin
        if (busy_first < 0) busy_first = c;
        busy_last = c;
        busy_n++;
      end
      start = (c == 0) || (c == v.start2_cyc);
      stop  = (c == v.stop_cyc);
      if (c == 0) begin
        burst_len  = NB_LEN'(v.len);
        continuous = 1'b0;
      end else if (c == v.lchg_cyc) begin
        burst_len = NB_LEN'(v.new_len);
      end
    end
    start = 1'b0;
    stop  = 1'b0;
    chk({v.name, " load_cycle"}, load_cyc, 1);
    chk({v.name, " strobes"}, strobes, v.exp_strobes);
    chk({v.name, " strobe_spacing_errs"}, spacing_err, 0);
    chk({v.name, " sym_strobe_vs_prbs_en"}, eq_err, 0);
    chk({v.name, " done_cycle"}, done_cyc, v.exp_done);
    chk({v.name, " busy_first"}, busy_first, 1);
    chk({v.name, " busy_last"}, busy_last, v.exp_busy_last);
    chk({v.name, " busy_len"}, busy_n, v.exp_busy_last);
    chk({v.name, " sym_cnt"}, int'(sym_cnt), v.exp_cnt);
  endtask

  initial begin
    int loads, last_load, dn, bz, s4;

    //            name             len stop st2 lchg nlen str done blast cnt
    vecs[0] = '{"len3",            3, -1, -1, -1, 0, 3, 14, 14, 3};
    vecs[1] = '{"len0",            0, -1, -1, -1, 0, 0,  2,  2, 0};
    vecs[2] = '{"len10_stop10",   10, 10, -1, -1, 0, 2, -1, 10, 2};
    vecs[3] = '{"len1",            1, -1, -1, -1, 0, 1,  6,  6, 1};
    vecs[4] = '{"len2_pokes",      2, -1,  6,  4, 7, 2, 10, 10, 2};
    vecs[5] = '{"len4_stop_on_st", 4, 13, -1, -1, 0, 3, -1, 13, 3};
    vecs[6] = '{"len2_stop_load",  2,  1, -1, -1, 0, 2, 10, 10, 2};
    vecs[7] = '{"len1_stop_done",  1,  6, -1, -1, 0, 1,  6,  6, 1};

    rst = 1'b1;
    start = 1'b0; stop = 1'b0; continuous = 1'b0; burst_len = '0;
    start4 = 1'b0; stop4 = 1'b0; cont4 = 1'b0; burst_len4 = '0;
    repeat (2) @(negedge clk);
    chk("rst prbs_load", int'(prbs_load), 0);
    chk("rst prbs_en", int'(prbs_en), 0);
    chk("rst sym_strobe", int'(sym_strobe), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst sym_cnt", int'(sym_cnt), 0);
    chk("seed_i", int'(seed_i), 'h1AA);
    chk("seed_q", int'(seed_q), 'h1FE);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst busy", int'(busy), 0);

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // start and stop together in IDLE: not accepted, sym_cnt keeps the last burst's count.
    @(negedge clk);
    burst_len = NB_LEN'(5); start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("start_stop prbs_load", int'(prbs_load), 0);
    chk("start_stop busy", int'(busy), 0);
    @(negedge clk);
    chk("start_stop busy_later", int'(busy), 0);
    chk("start_stop sym_cnt_hold", int'(sym_cnt), 1);

    // start held high: ignored while busy, accepted again in the first IDLE cycle.
    loads = 0; last_load = -1;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (prbs_load) begin
        loads++;
        last_load = c;
      end
      start = 1'b1;
      burst_len = NB_LEN'(1);
    end
    start = 1'b0;
    chk("restart loads", loads, 2);
    chk("restart load_cycle", last_load, 8);
    repeat (12) @(negedge clk);
    chk("restart idle", int'(busy), 0);

    // Reset asserted in cycle 7 of a running burst.
    dn = 0; bz = 0;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      if (c == 7) chk("mid_rst sym_cnt_before", int'(sym_cnt), 1);
      start = (c == 0);
      burst_len = NB_LEN'(10);
    end
    rst = 1'b1;
    #1;
    chk("mid_rst busy", int'(busy), 0);
    chk("mid_rst sym_cnt", int'(sym_cnt), 0);
    chk("mid_rst prbs_en", int'(prbs_en), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done) dn++;
      if (busy) bz++;
    end
    chk("mid_rst no_done", dn, 0);
    chk("mid_rst no_busy", bz, 0);

    // Continuous mode on the 4-bit counter instance: wrap 15 -> 0 -> 1, then stop.
    s4 = 0; dn = 0;
    for (int c = 0; c <= 73; c++) begin
      @(negedge clk);
      if (prbs_en4 && c <= 70) s4++;
      if (done4) dn++;
      if (c == 62) chk("cont sym_cnt_c62", int'(sym_cnt4), 15);
      if (c == 66) chk("cont sym_cnt_c66", int'(sym_cnt4), 0);
      if (c == 70) begin
        chk("cont sym_cnt_c70", int'(sym_cnt4), 1);
        chk("cont busy_c70", int'(busy4), 1);
      end
      if (c == 72) chk("cont busy_after_stop", int'(busy4), 0);
      start4 = (c == 0);
      cont4  = (c == 0);
      burst_len4 = NB_L4'(2);
      stop4  = (c == 71);
    end
    stop4 = 1'b0;
    chk("cont strobes", s4, 17);
    chk("cont no_done", dn, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
